// File: rtl/check_message_fsm.sv
// Scans every byte of the decrypted message in d_ram and decides whether it is plausible
// plaintext (lowercase letters or space), stopping at the first rejected byte.
module check_message_fsm #(
    parameter int data_width = 8,
    parameter int addr_width = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  check_message_start,
    output logic                  check_message_finish,
    output logic                  message_valid,
    output logic [addr_width-1:0] first_bad_addr,
    output logic                  d_ram_access_request,
    input  logic                  d_ram_access_granted,
    output logic [addr_width-1:0] d_ram_addr,
    input  logic [data_width-1:0] d_ram_q
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQUEST = 3'd1;
    localparam logic [2:0] S_READ    = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;

    localparam logic [addr_width-1:0] K_LAST = '1;

    logic [2:0]            r_state;
    logic [addr_width-1:0] r_k;
    logic                  r_message_valid;
    logic [addr_width-1:0] r_first_bad_addr;
    logic                  w_hi_zero;
    logic                  w_byte_ok;

    function automatic logic is_plain_char(input logic [7:0] b);
        return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    // Anything above the low byte must be clear for the word to count as a character.
    if (data_width > 8) begin : g_wide
        assign w_hi_zero = ~|d_ram_q[data_width-1:8];
    end else begin : g_narrow
        assign w_hi_zero = 1'b1;
    end

    assign w_byte_ok = w_hi_zero && is_plain_char(d_ram_q[7:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_k              <= '0;
            r_message_valid  <= 1'b0;
            r_first_bad_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (check_message_start) begin
                        r_state          <= S_REQUEST;
                        r_message_valid  <= 1'b0;
                        r_first_bad_addr <= '0;
                    end
                end
                S_REQUEST: begin
                    if (d_ram_access_granted) begin
                        r_state <= S_READ;
                        r_k     <= '0;
                    end
                end
                S_READ:  r_state <= S_WAIT;
                S_WAIT:  r_state <= S_CHECK;
                S_CHECK: begin
                    // Last-byte test precedes the increment so k never wraps.
                    if (!w_byte_ok) begin
                        r_message_valid  <= 1'b0;
                        r_first_bad_addr <= r_k;
                        r_state          <= S_FINISH;
                    end else if (r_k == K_LAST) begin
                        r_message_valid <= 1'b1;
                        r_state         <= S_FINISH;
                    end else begin
                        r_k     <= r_k + 1'b1;
                        r_state <= S_READ;
                    end
                end
                S_FINISH: begin
                    if (!check_message_start) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign check_message_finish = (r_state == S_FINISH);
    assign d_ram_access_request = (r_state == S_REQUEST) || (r_state == S_READ) ||
                                  (r_state == S_WAIT)    || (r_state == S_CHECK);
    assign d_ram_addr           = r_k;
    assign message_valid        = r_message_valid;
    assign first_bad_addr       = r_first_bad_addr;

endmodule

// File: tb/tb_check_message_fsm.sv
// Directed bench for check_message_fsm: a registered 32-byte RAM model feeds the scanner and
// each step checks finish timing, verdict registers and address activity.
module tb_check_message_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       finish;
    logic       mvalid;
    logic [4:0] bad_addr;
    logic       req;
    logic       gnt = 1'b0;
    logic [4:0] addr;
    logic [7:0] q = 8'h00;

    logic [7:0] mem [0:31];
    int         cnt [0:31];
    int         cyc;
    int         fin;
    int         checks = 0;
    int         errors = 0;
    string      msg = "the quick brown fox jumps over a";
    logic [7:0] bvals [0:5] = '{8'h60, 8'h61, 8'h7A, 8'h7B, 8'h20, 8'h21};
    logic       bexp  [0:5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    check_message_fsm #(.data_width(8), .addr_width(5)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .check_message_start  (start),
        .check_message_finish (finish),
        .message_valid        (mvalid),
        .first_bad_addr       (bad_addr),
        .d_ram_access_request (req),
        .d_ram_access_granted (gnt),
        .d_ram_addr           (addr),
        .d_ram_q              (q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) q <= mem[addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_msg();
        for (int i = 0; i < 32; i++) mem[i] = msg[i];
    endtask

    // Start at edge 0; grant rises after gdelay REQUEST cycles; returns first finish cycle or -1.
    task automatic run_scan(input int gdelay, input int limit, output int f);
        for (int a = 0; a < 32; a++) cnt[a] = 0;
        gnt   = (gdelay == 0);
        start = 1'b1;
        cyc   = 0;
        while (!finish && cyc < limit) begin
            step();
            if (cyc == 1 + gdelay) gnt = 1'b1;
            if (req && cyc >= 2 + gdelay) cnt[addr]++;
        end
        f = finish ? cyc : -1;
    endtask

    task automatic back_to_idle();
        start = 1'b0;
        step();
        step();
    endtask

    initial begin
        cyc = 0;
        load_msg();

        // Reset and idle
        rst = 1'b1; start = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_finish", finish, 0);
        chk("rst_req", req, 0);
        chk("rst_valid", mvalid, 0);
        chk("rst_bad", bad_addr, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_finish", finish, 0);
            chk("idle_req", req, 0);
            chk("idle_addr", addr, 0);
        end

        // All-valid message
        run_scan(0, 200, fin);
        chk("allv_fin_cycle", fin, 98);
        chk("allv_valid", mvalid, 1);
        chk("allv_req_low", req, 0);
        for (int a = 0; a < 32; a++) chk("allv_addr_cnt", cnt[a], 3);
        back_to_idle();

        // Early reject at byte 5
        mem[5] = 8'h41;
        run_scan(0, 200, fin);
        chk("rej_fin_cycle", fin, 20);
        chk("rej_valid", mvalid, 0);
        chk("rej_bad", bad_addr, 5);
        chk("rej_cnt5", cnt[5], 3);
        chk("rej_cnt6", cnt[6], 0);
        back_to_idle();
        load_msg();

        // Class boundaries at the last address
        for (int t = 0; t < 6; t++) begin
            mem[31] = bvals[t];
            run_scan(0, 200, fin);
            chk("bnd_fin_cycle", fin, 98);
            chk("bnd_valid", mvalid, bexp[t]);
            if (!bexp[t]) chk("bnd_bad31", bad_addr, 31);
            back_to_idle();
        end
        load_msg();

        // Grant delay, entry clearing, and finish/start handshake
        gnt = 1'b0; start = 1'b1; cyc = 0;
        step();
        chk("gd_req_entry", req, 1);
        chk("gd_bad_cleared", bad_addr, 0);
        chk("gd_valid_cleared", mvalid, 0);
        start = 1'b0;
        rst = 1'b1; step(); rst = 1'b0; step();
        run_scan(7, 250, fin);
        chk("gd_fin_cycle", fin, 105);
        chk("gd_valid", mvalid, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hs_finish_hold", finish, 1);
        end
        start = 1'b0;
        step();
        chk("hs_idle_finish", finish, 0);
        chk("hs_idle_req", req, 0);
        chk("hs_idle_valid_kept", mvalid, 1);
        step();
        start = 1'b1;
        step();
        chk("hs_second_req", req, 1);
        chk("hs_second_valid_clr", mvalid, 0);
        rst = 1'b1; start = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Mid-scan reset in the CHECK of byte 10
        gnt = 1'b1; start = 1'b1; cyc = 0;
        while (cyc < 34) step();
        chk("mid_addr_k10", addr, 10);
        chk("mid_req_high", req, 1);
        rst = 1'b1;
        step();
        chk("mid_req", req, 0);
        chk("mid_finish", finish, 0);
        chk("mid_valid", mvalid, 0);
        chk("mid_addr0", addr, 0);
        rst = 1'b0;
        back_to_idle();
        run_scan(0, 200, fin);
        chk("mid_rescan_fin", fin, 98);
        chk("mid_rescan_valid", mvalid, 1);
        chk("mid_rescan_cnt0", cnt[0], 3);
        chk("mid_rescan_cnt31", cnt[31], 3);
        back_to_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
